// File: rtl/logic_op_pkg.sv
// Shared opcode encoding and skid-buffer state type for the logic_op_pipe block.
package logic_op_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND     = 3'd0,
    OP_OR      = 3'd1,
    OP_XOR     = 3'd2,
    OP_NOT     = 3'd3,
    OP_XNOR    = 3'd4,
    OP_NAND    = 3'd5,
    OP_NOR     = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/logic_op_pipe_if.sv
// Operand/result bus of logic_op_pipe: valid/ready input port, valid/ready output port.
interface logic_op_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) ();
  import logic_op_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_err;
  logic [CNT_W-1:0] out_cnt;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_y, out_err, out_cnt
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_y, out_err, out_cnt
  );

endinterface

// File: rtl/logic_op_skid.sv
// Generic 2-entry skid buffer: main register drives the output, skid register
// absorbs one extra beat so the registered ready never drops data.
module logic_op_skid
  import logic_op_pkg::*;
#(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  input  logic [DW-1:0] s_data_i,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [DW-1:0] m_data_o
);

  skid_state_e   state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          ready_q, ready_d;
  logic          accept;
  logic          drain;

  assign accept = s_valid_i && ready_q;
  assign drain  = (state_q != ST_EMPTY) && m_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    ready_d = 1'b1;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = s_data_i;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        // Accept and drain together reload main in place: no bubble.
        if (accept && drain) begin
          main_d = s_data_i;
        end else if (accept) begin
          skid_d  = s_data_i;
          state_d = ST_TWO;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign s_ready_o = ready_q;
  assign m_valid_o = (state_q != ST_EMPTY);
  assign m_data_o  = main_q;

endmodule

// File: rtl/logic_op_pipe.sv
// Bitwise gate front end: opcode decode + gate function feeding a 2-entry skid
// buffer. Define LOGIC_OP_CNT_EN to enable the saturating output transfer counter.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  logic_op_pipe_if.slave bus
);

  logic [WIDTH-1:0] y_c;
  logic             err_c;
  logic [WIDTH:0]   res_c;
  logic [WIDTH:0]   out_data;

  always_comb begin
    y_c   = '0;
    err_c = 1'b0;
    case (bus.in_op)
      OP_AND:  y_c = bus.in_a & bus.in_b;
      OP_OR:   y_c = bus.in_a | bus.in_b;
      OP_XOR:  y_c = bus.in_a ^ bus.in_b;
      OP_NOT:  y_c = ~bus.in_a;
      OP_XNOR: y_c = ~(bus.in_a ^ bus.in_b);
      OP_NAND: y_c = ~(bus.in_a & bus.in_b);
      OP_NOR:  y_c = ~(bus.in_a | bus.in_b);
      default: begin
        y_c   = '0;
        err_c = 1'b1;
      end
    endcase
  end

  // The error flag rides along as the top bit of the buffered word.
  assign res_c = {err_c, y_c};

  logic_op_skid #(
    .DW(WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid_i (bus.in_valid),
    .s_ready_o (bus.in_ready),
    .s_data_i  (res_c),
    .m_valid_o (bus.out_valid),
    .m_ready_i (bus.out_ready),
    .m_data_o  (out_data)
  );

  assign bus.out_y   = out_data[WIDTH-1:0];
  assign bus.out_err = out_data[WIDTH];

`ifdef LOGIC_OP_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.out_valid && bus.out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.out_cnt = cnt_q;
`else
  assign bus.out_cnt = '0;
`endif

endmodule

// File: tb/tb_logic_op_pipe.sv
// Self-checking bench for logic_op_pipe: a 2-deep FIFO model checked every
// cycle, plus directed vectors with literal expectations.
module tb_logic_op_pipe;
  import logic_op_pkg::*;

  localparam int W = 8;
`ifdef LOGIC_OP_CNT_EN
  localparam int CW = 4;
  localparam bit CNT_ON = 1'b1;
`else
  localparam int CW = 16;
  localparam bit CNT_ON = 1'b0;
`endif
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_op_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  logic_op_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [W:0] q[$];
  logic [W:0] got[$];
  int ndrain = 0;
  int cnt_m = 0;
  bit up = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference result {err, y} straight from the opcode table.
  function automatic logic [W:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] y;
    case (op)
      3'd0: y = a & b;
      3'd1: y = a | b;
      3'd2: y = a ^ b;
      3'd3: y = ~a;
      3'd4: y = ~(a ^ b);
      3'd5: y = ~(a & b);
      3'd6: y = ~(a | b);
      default: return {1'b1, {W{1'b0}}};
    endcase
    return {1'b0, y};
  endfunction

  // Compare process: outputs are checked mid-cycle, then the model advances
  // by what the coming rising edge must do.
  always @(negedge clk) begin
    bit exp_ready;
    bit drain;
    bit acc;
    if (!rst_n) begin
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_y", 32'(bus.out_y), 32'd0);
      chk("rst_out_err", 32'(bus.out_err), 32'd0);
      chk("rst_out_cnt", 32'(bus.out_cnt), 32'd0);
      q.delete();
      cnt_m = 0;
      up = 1'b0;
    end else begin
      exp_ready = up && (q.size() < 2);
      chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("out_y", 32'(bus.out_y), 32'(q[0][W-1:0]));
        chk("out_err", 32'(bus.out_err), 32'(q[0][W]));
      end
      chk("out_cnt", 32'(bus.out_cnt), CNT_ON ? 32'(cnt_m) : 32'd0);
      drain = (q.size() != 0) && bus.out_ready;
      acc = exp_ready && bus.in_valid;
      if (drain) begin
        got.push_back({bus.out_err, bus.out_y});
        void'(q.pop_front());
        ndrain++;
        if (cnt_m < CNT_MAX) cnt_m++;
      end
      if (acc) q.push_back(model(bus.in_op, bus.in_a, bus.in_b));
      up = 1'b1;
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc;
    int n;
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_a = a;
    bus.in_b = b;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted at %0t", $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [W:0] t1_exp [7] = '{9'h030, 9'h0FC, 9'h0CC, 9'h00F, 9'h033, 9'h0CF, 9'h003};
  logic [W:0] t3_exp [3] = '{9'h003, 9'h0FF, 9'h00A};

  initial begin
    time t0;
    int d0;
    bus.in_valid = 1'b0;
    bus.in_op = '0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b1;

    idle(2);
    chk("hold_rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    idle(1);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);

    // Test 1: every legal opcode on F0/3C, one beat per cycle.
    got.delete();
    chk("t1_idle_out_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 7; i++) begin
      send(3'(i), 8'hF0, 8'h3C);
      if (i == 0) chk("t1_latency", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    idle(3);
    chk("t1_count", 32'(got.size()), 32'd7);
    for (int i = 0; i < 7 && i < got.size(); i++) begin
      chk($sformatf("t1_beat%0d", i), 32'(got[i]), 32'(t1_exp[i]));
    end

    // Test 2: illegal opcode, then a legal one.
    got.delete();
    send(3'd7, 8'hFF, 8'hFF);
    send(3'd0, 8'hFF, 8'hFF);
    bus.in_valid = 1'b0;
    idle(3);
    chk("t2_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("t2_illegal", 32'(got[0]), 32'h100);
      chk("t2_legal", 32'(got[1]), 32'h0FF);
    end

    // Test 3: backpressure fills both entries.
    got.delete();
    bus.out_ready = 1'b0;
    send(3'd1, 8'h01, 8'h02);
    send(3'd2, 8'h0F, 8'hF0);
    bus.in_op = 3'd0;
    bus.in_a = 8'hAA;
    bus.in_b = 8'h0F;
    chk("t3_full_in_ready", 32'(bus.in_ready), 32'd0);
    idle(1);
    chk("t3_stall_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t3_stall_y", 32'(bus.out_y), 32'h03);
    bus.out_ready = 1'b1;
    send(3'd0, 8'hAA, 8'h0F);
    bus.in_valid = 1'b0;
    idle(4);
    chk("t3_ready_back", 32'(bus.in_ready), 32'd1);
    chk("t3_count", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      chk($sformatf("t3_beat%0d", i), 32'(got[i]), 32'(t3_exp[i]));
    end

    // Test 4: 100 back-to-back beats must take exactly 101 cycles.
    t0 = $time;
    d0 = ndrain;
    for (int i = 0; i < 100; i++) begin
      send(3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom));
    end
    bus.in_valid = 1'b0;
    idle(1);
    chk("t4_drains", 32'(ndrain - d0), 32'd100);
    chk("t4_cycles", 32'(($time - t0) / 10), 32'd101);

    // Test 5: random valid and backpressure.
    for (int i = 0; i < 1000; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_op = 3'($urandom_range(0, 7));
      bus.in_a = 8'($urandom);
      bus.in_b = 8'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      idle(1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    idle(4);
    chk("t5_drained", 32'(bus.out_valid), 32'd0);

    // Test 6: reset while both entries are full.
    bus.out_ready = 1'b0;
    send(3'd0, 8'h12, 8'h34);
    send(3'd1, 8'h56, 8'h78);
    bus.in_valid = 1'b0;
    chk("t6_two_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_async_out_y", 32'(bus.out_y), 32'd0);
    idle(2);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    idle(3);
    chk("t6_no_stale", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 20; i++) send(3'd2, 8'(i), 8'h55);
    bus.in_valid = 1'b0;
    idle(3);
    chk("t6_cnt", 32'(bus.out_cnt), CNT_ON ? 32'd15 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
